b20_extend_filter: RTL and testbench

//  Sequencer/filter stage directly downstream of the 20-bit filter-input enumerator (crypto1 attack path).

---
 rtl/crypto1_nlf_pkg.sv | 29 ++
 rtl/b20_surv_fifo.sv | 50 +++++
 rtl/b20_extend_filter.sv | 153 +++++++++++++++
 tb/tb_b20_extend_filter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/crypto1_nlf_pkg.sv
// Crypto1 nonlinear filter tables, the 20-bit filter function and the
// sequencer state encoding shared by the extend/filter stage.
package crypto1_nlf_pkg;

    localparam logic [15:0] FA_TBL = 16'h9E98;
    localparam logic [15:0] FB_TBL = 16'hB48E;
    localparam logic [31:0] FC_TBL = 32'hEC57E80A;

    localparam int KEY_W  = 20;
    localparam int CAND_W_OUT = 21;
    localparam int SURV_W = 17;
    localparam int ERR_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EVAL  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Two-level filter: five 4-bit subfunctions feed the 5-input output table.
    function automatic logic nlf20(input logic [19:0] w);
        logic [4:0] idx;
        idx = {FB_TBL[w[3:0]], FA_TBL[w[7:4]], FA_TBL[w[11:8]],
               FB_TBL[w[15:12]], FA_TBL[w[19:16]]};
        return FC_TBL[idx];
    endfunction

endpackage

// File: rtl/b20_surv_fifo.sv
// Survivor FIFO: up to two writes per cycle (compacted, wd0 first), one read
// per cycle. The caller guarantees room for the writes it issues.
module b20_surv_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = 21
) (
    input  logic                        CLK,
    input  logic                        RESETn,
    input  logic [1:0]                  i_wr_n,
    input  logic [WIDTH-1:0]            i_wd0,
    input  logic [WIDTH-1:0]            i_wd1,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_head,
    output logic                        o_empty,
    output logic [$clog2(FIFO_DEPTH):0] o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Storage writes: first entry at the write pointer, second right after it.
    always_ff @(posedge CLK) begin
        if (i_wr_n != 2'd0) r_mem[r_wptr] <= i_wd0;
        if (i_wr_n == 2'd2) r_mem[r_wptr + AW'(1)] <= i_wd1;
    end

    // Pointer and occupancy bookkeeping; reset discards any contents.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(i_wr_n);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(i_wr_n) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/b20_extend_filter.sv
// Sequencer/filter downstream of the 20-bit candidate enumerator: fetches each
// candidate, checks it against KS0, extends it by one LSB and keeps children
// whose filter output matches KS1. Survivors leave through a small FIFO.
module b20_extend_filter
    import crypto1_nlf_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CAND_W     = 15
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        START,
    input  logic        KS0,
    input  logic        KS1,
    output logic        ENUM_BIT,
    output logic        ENUM_STB,
    input  logic [19:0] ENUM_KEY,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [20:0] OUT_CAND,
    output logic        BUSY,
    output logic        DONE,
    output logic [16:0] SURV_CNT,
    output logic [15:0] ERR_CNT
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t              r_state;
    state_t              w_next;
    logic                r_ks0;
    logic                r_ks1;
    logic [19:0]         r_parent;
    logic [CAND_W-1:0]   r_cand;
    logic [SURV_W-1:0]   r_surv;
    logic [ERR_W-1:0]    r_err;

    logic                w_stb;
    logic                w_done;
    logic [1:0]          w_wr_n;
    logic [20:0]         w_wd0;
    logic [20:0]         w_wd1;
    logic [20:0]         w_head;
    logic                w_empty;
    logic [CNT_W-1:0]    w_count;
    logic                w_room;
    logic                w_par_ok;
    logic                w_s0;
    logic                w_s1;
    logic [1:0]          w_surv_n;
    logic                w_pop;

    // Filter evaluation on the registered parent and its two children.
    assign w_par_ok = (nlf20(r_parent) == r_ks0);
    assign w_s0     = (nlf20({r_parent[18:0], 1'b0}) == r_ks1);
    assign w_s1     = (nlf20({r_parent[18:0], 1'b1}) == r_ks1);
    assign w_surv_n = {1'b0, w_s0} + {1'b0, w_s1};
    assign w_wd0    = w_s0 ? {r_parent, 1'b0} : {r_parent, 1'b1};
    assign w_wd1    = {r_parent, 1'b1};

    // Only fetch when both children of the next parent are guaranteed a slot.
    assign w_room   = (w_count <= CNT_W'(FIFO_DEPTH - 2));
    assign w_pop    = OUT_VALID && OUT_READY;

    assign ENUM_BIT  = r_ks0;
    assign ENUM_STB  = w_stb;
    assign OUT_VALID = !w_empty;
    assign OUT_CAND  = w_empty ? '0 : w_head;
    assign BUSY      = (r_state != IDLE);
    assign DONE      = w_done;
    assign SURV_CNT  = r_surv;
    assign ERR_CNT   = r_err;

    b20_surv_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (21)
    ) u_fifo (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .i_wr_n  (w_wr_n),
        .i_wd0   (w_wd0),
        .i_wd1   (w_wd1),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESETn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next-state, enumerator strobe, FIFO write count and completion pulse.
    always_comb begin
        w_next = r_state;
        w_stb  = 1'b0;
        w_done = 1'b0;
        w_wr_n = 2'd0;
        case (r_state)
            IDLE: begin
                if (START) w_next = FETCH;
            end
            FETCH: begin
                if (w_room) begin
                    w_stb  = 1'b1;
                    w_next = EVAL;
                end
            end
            EVAL: begin
                if (w_par_ok) w_wr_n = w_surv_n;
                w_next = (r_cand == '1) ? FLUSH : FETCH;
            end
            FLUSH: begin
                if (w_empty) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Parent capture in the same cycle the enumerator is told to advance.
    always_ff @(posedge CLK) begin
        if (w_stb) r_parent <= ENUM_KEY;
    end

    // Keystream latches, candidate counter and result counters.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_ks0  <= 1'b0;
            r_ks1  <= 1'b0;
            r_cand <= '0;
            r_surv <= '0;
            r_err  <= '0;
        end else if (r_state == IDLE) begin
            if (START) begin
                r_ks0  <= KS0;
                r_ks1  <= KS1;
                r_cand <= '0;
                r_surv <= '0;
                r_err  <= '0;
            end
        end else if (r_state == EVAL) begin
            r_cand <= r_cand + 1'b1;
            if (w_par_ok)          r_surv <= r_surv + SURV_W'(w_surv_n);
            else if (r_err != '1)  r_err  <= r_err + 1'b1;
        end
    end

endmodule

// File: tb/tb_b20_extend_filter.sv
// Bench for b20_extend_filter with a table-driven enumerator stub. The sweep
// length is shortened through CAND_W so several sweeps fit in a short run.
module tb_b20_extend_filter;
    import crypto1_nlf_pkg::nlf20;

    localparam int CW = 8;
    localparam int N  = 1 << CW;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        START = 1'b0;
    logic        KS0 = 1'b0;
    logic        KS1 = 1'b0;
    logic        OUT_READY = 1'b1;
    logic        ENUM_BIT, ENUM_STB, OUT_VALID, BUSY, DONE;
    logic [19:0] ENUM_KEY;
    logic [20:0] OUT_CAND;
    logic [16:0] SURV_CNT;
    logic [15:0] ERR_CNT;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    b20_extend_filter #(.FIFO_DEPTH(8), .CAND_W(CW)) dut (
        .CLK(CLK), .RESETn(RESETn), .START(START), .KS0(KS0), .KS1(KS1),
        .ENUM_BIT(ENUM_BIT), .ENUM_STB(ENUM_STB), .ENUM_KEY(ENUM_KEY),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_CAND(OUT_CAND),
        .BUSY(BUSY), .DONE(DONE), .SURV_CNT(SURV_CNT), .ERR_CNT(ERR_CNT)
    );

    // Enumerator stub: counter stepped by ENUM_STB, key looked up in a table.
    logic [19:0] tbl [N];
    logic [CW-1:0] ectr;
    always @(posedge CLK) begin
        if (!RESETn)       ectr <= '0;
        else if (ENUM_STB) ectr <= ectr + 1'b1;
    end
    assign ENUM_KEY = tbl[ectr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fa_ref(input logic [3:0] n);
        return int'((16'h9E98 >> n) & 16'h1);
    endfunction
    function automatic int fb_ref(input logic [3:0] n);
        return int'((16'hB48E >> n) & 16'h1);
    endfunction
    function automatic bit ref_nlf(input logic [19:0] w);
        int idx;
        idx = 16 * fb_ref(w[3:0]) + 8 * fa_ref(w[7:4]) + 4 * fa_ref(w[11:8])
            + 2 * fb_ref(w[15:12]) + fa_ref(w[19:16]);
        return ((32'hEC57E80A >> idx) & 32'h1) != 0;
    endfunction

    // Expected survivor stream and counters for one sweep over the table.
    logic [20:0] expq[$];
    int exp_surv, exp_err;
    task automatic build_model(input bit k0, input bit k1);
        expq.delete();
        exp_surv = 0;
        exp_err  = 0;
        for (int i = 0; i < N; i++) begin
            logic [19:0] p;
            p = tbl[i];
            if (ref_nlf(p) != k0) exp_err++;
            else begin
                for (int b = 0; b < 2; b++) begin
                    logic [19:0] c;
                    c = {p[18:0], b[0]};
                    if (ref_nlf(c) == k1) begin
                        expq.push_back({p, b[0]});
                        exp_surv++;
                    end
                end
            end
        end
    endtask

    task automatic fill_const(input logic [19:0] v);
        for (int i = 0; i < N; i++) tbl[i] = v;
    endtask

    task automatic fill_random(input bit k, input int bad_per_16);
        for (int i = 0; i < N; i++) begin
            bit want;
            logic [19:0] v;
            want = ($urandom_range(15) < bad_per_16) ? ~k : k;
            v = 20'($urandom);
            for (int j = 0; j < 200 && ref_nlf(v) != want; j++) v = 20'($urandom);
            tbl[i] = v;
        end
    endtask

    // Output monitor, sampled on the falling edge.
    bit          mon_en = 0;
    int          stb_cnt = 0;
    int          done_cnt = 0;
    bit          valid_seen = 0;
    bit          prev_hold = 0;
    logic [20:0] prev_cand = '0;
    always @(negedge CLK) begin
        if (mon_en) begin
            if (ENUM_STB) stb_cnt++;
            if (DONE) done_cnt++;
            if (OUT_VALID) valid_seen = 1;
            if (prev_hold && OUT_VALID) chk("hold_stable", 32'(OUT_CAND), 32'(prev_cand));
            if (OUT_VALID && OUT_READY) begin
                if (expq.size() == 0) chk("surv_unexpected_qsize", 32'(expq.size()), 1);
                else chk("surv", 32'(OUT_CAND), 32'(expq.pop_front()));
            end
            prev_hold = OUT_VALID && !OUT_READY;
            prev_cand = OUT_CAND;
        end
    end

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_valid"}, 32'(OUT_VALID), 0);
        chk({nm, "_cand"}, 32'(OUT_CAND), 0);
        chk({nm, "_surv"}, 32'(SURV_CNT), 0);
        chk({nm, "_err"}, 32'(ERR_CNT), 0);
        chk({nm, "_busy"}, 32'(BUSY), 0);
        chk({nm, "_done"}, 32'(DONE), 0);
        chk({nm, "_stb"}, 32'(ENUM_STB), 0);
        chk({nm, "_bit"}, 32'(ENUM_BIT), 0);
    endtask

    task automatic run_sweep(input bit k0, input bit k1, input bit poke,
                             input bit stall, input bit expect_valid, input string nm);
        int cyc;
        int stb_snap;
        build_model(k0, k1);
        stb_cnt = 0; done_cnt = 0; valid_seen = 0; prev_hold = 0; stb_snap = 0;
        mon_en = 1;
        START = 1; KS0 = k0; KS1 = k1;
        @(posedge CLK); #1;
        START = 0;
        chk({nm, "_busy_start"}, 32'(BUSY), 1);
        chk({nm, "_enum_bit"}, 32'(ENUM_BIT), 32'(k0));
        cyc = 0;
        while (done_cnt == 0 && cyc < 6000) begin
            @(posedge CLK); #1;
            cyc++;
            if (poke && cyc == 100) begin START = 1; KS0 = ~k0; KS1 = ~k1; end
            if (poke && cyc == 101) begin
                START = 0;
                chk({nm, "_poke_bit"}, 32'(ENUM_BIT), 32'(k0));
                chk({nm, "_poke_busy"}, 32'(BUSY), 1);
            end
            if (stall && cyc == 150) OUT_READY = 0;
            if (stall && cyc == 300) stb_snap = stb_cnt;
            if (stall && cyc == 640) begin
                chk({nm, "_stall_stb"}, 32'(stb_cnt), 32'(stb_snap));
                chk({nm, "_stall_full"}, 32'(OUT_VALID), 1);
                OUT_READY = 1;
            end
        end
        chk({nm, "_done_seen"}, 32'(done_cnt > 0), 1);
        repeat (3) @(posedge CLK);
        #1;
        chk({nm, "_done_once"}, 32'(done_cnt), 1);
        chk({nm, "_stb_total"}, 32'(stb_cnt), 32'(N));
        chk({nm, "_surv_cnt"}, 32'(SURV_CNT), 32'(exp_surv));
        chk({nm, "_err_cnt"}, 32'(ERR_CNT), 32'(exp_err));
        chk({nm, "_left"}, 32'(expq.size()), 0);
        chk({nm, "_idle"}, 32'(BUSY), 0);
        chk({nm, "_valid_seen"}, 32'(valid_seen), 32'(expect_valid));
        mon_en = 0;
        KS0 = 0; KS1 = 0;
    endtask

    initial begin
        fill_const(20'h00000);
        RESETn = 0;
        repeat (3) @(posedge CLK);
        #1;
        check_idle_outputs("reset");
        RESETn = 1;

        chk("nlf_00000", 32'(nlf20(20'h00000)), 0);
        chk("nlf_00001", 32'(nlf20(20'h00001)), 1);
        for (int i = 0; i < 16; i++) begin
            logic [19:0] v;
            v = 20'($urandom);
            chk("nlf_rand", 32'(nlf20(v)), 32'(ref_nlf(v)));
        end

        // Constant zero parent: only the 0-extended child survives each time.
        fill_const(20'h00000);
        run_sweep(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "zero_ks00");
        chk("zero_ks00_all", 32'(SURV_CNT), 32'(N));

        // Random parents with some inconsistent ones, ignored START, long stall.
        fill_random(1'b1, 2);
        run_sweep(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "rand_ks10");

        // Every parent fails the KS0 check.
        fill_const(20'h00000);
        run_sweep(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "zero_ks10");
        chk("zero_ks10_err", 32'(ERR_CNT), 32'(N));

        // Reset in the middle of a sweep, then a complete sweep.
        fill_random(1'b0, 1);
        build_model(1'b0, 1'b1);
        stb_cnt = 0; done_cnt = 0; prev_hold = 0;
        mon_en = 1;
        START = 1; KS0 = 1'b0; KS1 = 1'b1;
        @(posedge CLK); #1;
        START = 0;
        repeat (200) @(posedge CLK);
        #1;
        mon_en = 0;
        RESETn = 0;
        @(posedge CLK); #1;
        check_idle_outputs("midreset");
        chk("midreset_no_done", 32'(done_cnt), 0);
        RESETn = 1;
        @(posedge CLK); #1;
        run_sweep(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
